// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered result stage behind the combinational alu. Results (y plus
//   N/Z/C/V) enter through a valid/ready handshake. They are held in a
//   2-entry skid FIFO until the writeback consumer takes them. The
//   architectural NZCV register is updated when a result is accepted.
//
//   Optional feature macro: ALU_RESULT_STAGE_STICKY_OV_EN
//     Adds clr_sticky / sticky_ov / ov_count. These are a sticky overflow
//     bit and a saturating overflow event counter. Without the macro,
//     these ports and their logic do not exist.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        producer handshake (in_ready from state only)
//   in_y, in_carry, in_overflow, in_zero, in_negative  ALU result
//   in_setflags                accepted result updates flags
//   out_valid / out_ready      consumer handshake on the FIFO head
//   out_y, out_flags           head entry ({N,Z,C,V}), 0 when empty
//   flags                      architectural {N,Z,C,V}
//   clr_sticky, sticky_ov, ov_count   optional overflow tracking
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags
`ifdef ALU_RESULT_STAGE_STICKY_OV_EN
  ,
  input  logic             clr_sticky,
  output logic             sticky_ov,
  output logic [CNT_W-1:0] ov_count
`endif
);

  logic [WIDTH-1:0] r_mem_y [2];
  logic [3:0]       r_mem_f [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic [3:0]       r_flags;

  logic       w_acc;
  logic       w_pop;
  logic [3:0] w_in_f;

  // in_ready comes from registered count only. A pop while full does
  // not reopen the input until the following cycle.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_acc     = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_in_f    = {in_negative, in_zero, in_carry, in_overflow};

  assign out_y     = out_valid ? r_mem_y[r_rptr] : '0;
  assign out_flags = out_valid ? r_mem_f[r_rptr] : 4'b0000;
  assign flags     = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_y[i] <= '0;
        r_mem_f[i] <= 4'b0000;
      end
      r_wptr <= 1'b0;
    end else if (w_acc) begin
      r_mem_y[r_wptr] <= in_y;
      r_mem_f[r_wptr] <= w_in_f;
      r_wptr          <= ~r_wptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Flags follow accept time, not drain time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_flags <= 4'b0000;
    else if (w_acc & in_setflags) r_flags <= w_in_f;
  end

`ifdef ALU_RESULT_STAGE_STICKY_OV_EN
  logic             r_sticky;
  logic [CNT_W-1:0] r_ov_cnt;

  assign sticky_ov = r_sticky;
  assign ov_count  = r_ov_cnt;

  // If clear and an overflow accept happen in the same cycle, the clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_ov_cnt <= '0;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
      r_ov_cnt <= '0;
    end else if (w_acc & in_overflow) begin
      r_sticky <= 1'b1;
      if (r_ov_cnt != {CNT_W{1'b1}}) r_ov_cnt <= r_ov_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_carry, in_overflow, in_zero, in_negative, in_setflags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;
  logic [3:0]       flags;
`ifdef ALU_RESULT_STAGE_STICKY_OV_EN
  logic             clr_sticky;
  logic             sticky_ov;
  logic [CNT_W-1:0] ov_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_carry(in_carry), .in_overflow(in_overflow), .in_zero(in_zero),
    .in_negative(in_negative), .in_setflags(in_setflags),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flags(out_flags), .flags(flags)
`ifdef ALU_RESULT_STAGE_STICKY_OV_EN
    , .clr_sticky(clr_sticky), .sticky_ov(sticky_ov), .ov_count(ov_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit before the checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one result; flags are given as {N,Z,C,V}.
  task automatic drive(input logic [31:0] y, input logic [3:0] nzcv, input logic sf);
    in_valid    = 1'b1;
    in_y        = y;
    in_negative = nzcv[3];
    in_zero     = nzcv[2];
    in_carry    = nzcv[1];
    in_overflow = nzcv[0];
    in_setflags = sf;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_y = '0; in_carry = 1'b0; in_overflow = 1'b0;
    in_zero = 1'b0; in_negative = 1'b0; in_setflags = 1'b0; out_ready = 1'b0;
`ifdef ALU_RESULT_STAGE_STICKY_OV_EN
    clr_sticky = 1'b0;
`endif
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Pass-through
    out_ready = 1'b1;
    drive(32'h5, 4'b0000, 1'b1);
    tick();
    in_valid = 1'b0;
    check("pt_out_valid", {31'd0, out_valid}, 32'd1);
    check("pt_out_y", out_y, 32'h5);
    check("pt_out_flags", {28'd0, out_flags}, 32'd0);
    check("pt_flags", {28'd0, flags}, 32'd0);
    tick();
    check("pt_drained", {31'd0, out_valid}, 32'd0);

    // Stall and fill
    out_ready = 1'b0;
    drive(32'h1, 4'b0000, 1'b0);
    tick();
    drive(32'h2, 4'b0000, 1'b0);
    tick();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_head", out_y, 32'h1);
    drive(32'h3, 4'b0000, 1'b0);
    tick();
    check("blocked_head", out_y, 32'h1);
    check("blocked_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();  // pops 1; y=3 not accepted because in_ready was 0 before the edge
    check("drain1_y", out_y, 32'h2);
    check("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();  // pops 2, accepts 3
    check("drain2_y", out_y, 32'h3);
    check("drain2_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain3_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous push/pop with count=1
    out_ready = 1'b0;
    drive(32'hA, 4'b0000, 1'b0);
    tick();
    check("sim_head_a", out_y, 32'hA);
    out_ready = 1'b1;
    drive(32'hB, 4'b0000, 1'b0);
    tick();
    in_valid = 1'b0;
    check("sim_head_b", out_y, 32'hB);
    check("sim_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("sim_empty", {31'd0, out_valid}, 32'd0);

    // Flags gating
    drive(32'h8000_0000, 4'b1001, 1'b1);
    tick();
    check("fl_set", {28'd0, flags}, 32'h9);
    check("fl_out_flags", {28'd0, out_flags}, 32'h9);
    drive(32'h0, 4'b0100, 1'b0);
    tick();
    in_valid = 1'b0;
    check("fl_hold", {28'd0, flags}, 32'h9);
    check("fl_head_flags", {28'd0, out_flags}, 32'h4);
    tick();

    // Async reset while full
    out_ready = 1'b0;
    drive(32'h11, 4'b0000, 1'b0);
    tick();
    drive(32'h22, 4'b0000, 1'b0);
    tick();
    in_valid = 1'b0;
    check("ar_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_flags", {28'd0, flags}, 32'd0);
    check("ar_out_y", out_y, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check("ar_still_empty", {31'd0, out_valid}, 32'd0);

`ifdef ALU_RESULT_STAGE_STICKY_OV_EN
    out_ready = 1'b1;
    check("ov_rst", {29'd0, sticky_ov, ov_count}, 32'd0);
    drive(32'h1, 4'b0001, 1'b0);
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("ov_sticky", {31'd0, sticky_ov}, 32'd1);
    check("ov_cnt3", {30'd0, ov_count}, 32'd3);
    drive(32'h1, 4'b0001, 1'b0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    in_valid = 1'b0;
    check("ov_clr_sticky", {31'd0, sticky_ov}, 32'd0);
    check("ov_clr_cnt", {30'd0, ov_count}, 32'd0);
    drive(32'h1, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    check("ov_sat", {30'd0, ov_count}, 32'd3);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered result stage directly downstream of the combinational `alu`.
- Captures `y` and the carry/overflow/zero/negative flags through a valid/ready handshake.
- Buffers them in a 2-entry skid FIFO and maintains the architectural NZCV flag register.
- Decouples ALU timing from the writeback consumer; a stalled consumer never loses a result.

Parameters:
- WIDTH, 32, datapath width; must match the `alu` WIDTH.
- CNT_W, 8, width of the overflow event counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept a result
- in_y  input  WIDTH  ALU result y
- in_carry  input  1  ALU carry
- in_overflow  input  1  ALU overflow
- in_zero  input  1  ALU zero
- in_negative  input  1  ALU negative
- in_setflags  input  1  accepted result updates the flag register
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes the head entry
- out_y  output  WIDTH  head entry result
- out_flags  output  4  head entry flags {N,Z,C,V}
- flags  output  4  architectural flag register {N,Z,C,V}
- clr_sticky  input  1  clears the sticky/counter state (optional feature only)
- sticky_ov  output  1  sticky overflow (optional feature only)
- ov_count  output  CNT_W  overflow event count (optional feature only)

Behaviour:
- Reset (asynchronous, active-low):
  - Applies immediately on rst_n low, including mid-transfer.
  - Empties the FIFO: count=0, both pointers=0, out_valid=0.
  - out_y=0, out_flags=0, flags=4'b0000; sticky_ov=0 and ov_count=0 when the feature is present.
  - Entries held at reset are discarded.
  - in_ready=1 from the first cycle after rst_n rises.
- Storage: 2 entries of {y, N, Z, C, V}; 1-bit write and read pointers; 2-bit count (0..2).
- in_ready = (count != 2). It depends only on registered state, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Accept writes entry[wptr] and toggles wptr. Pop toggles rptr.
- out_valid = (count != 0). out_y/out_flags show entry[rptr]; they are 0 when count=0.
- Latency:
  - A result accepted at edge t is visible on out_* after edge t (one cycle) when the FIFO was empty.
  - No combinational input-to-output path.
- Count update:
  - Accept only: count+1.
  - Pop only: count-1.
  - Both: count unchanged. With count=1 the head is popped and the new entry becomes the head next cycle.
- Full (count=2): in_ready=0. A simultaneous pop frees a slot, but in_ready does not re-assert until the next cycle.
- Empty (count=0): out_valid=0; out_ready is ignored.
- Data stability: out_y/out_flags are held stable while out_valid=1 and out_ready=0.
- Flag register:
  - On Accept with in_setflags=1, flags <= {in_negative, in_zero, in_carry, in_overflow} at that edge.
  - Otherwise flags hold.
  - Updates happen at accept time, not drain time; a stalled consumer does not delay the flag update.
- in_* values are sampled only on Accept; they are don't-care otherwise.

Optional Feature:
- Macro: ALU_RESULT_STAGE_STICKY_OV_EN.
- When defined:
  - sticky_ov sets on any Accept with in_overflow=1 and holds until clr_sticky=1 or reset.
  - ov_count increments on each such Accept and saturates at 2^CNT_W-1.
  - If clr_sticky and an overflow Accept occur in the same cycle, clr wins: sticky_ov=0, ov_count=0.
- When undefined:
  - The clr_sticky, sticky_ov and ov_count ports are absent, with no extra logic.
  - All other behaviour is identical.

Test Plan:
- Pass-through: reset; out_ready=1; one accept of y=32'h0000_0005, flags C=0,V=0,N=0,Z=0, setflags=1 -> next cycle out_valid=1, out_y=32'h0000_0005, out_flags=4'b0000; flags=4'b0000.
- Stall and fill:
  - out_ready=0; accept y=32'h1 then y=32'h2 -> count=2, in_ready=0.
  - A third in_valid with y=32'h3 is not accepted.
  - Raise out_ready -> consumer sees 32'h1, then 32'h2, in order; 32'h3 is accepted only after in_ready returns to 1.
- Simultaneous push/pop: count=1 holding 32'hA, out_ready=1, accept 32'hB -> next cycle out_y=32'hB and count=1.
- Flags gating:
  - Accept y=32'h8000_0000 with N=1,V=1, setflags=1 -> flags=4'b1001.
  - Then accept y=0 with Z=1, setflags=0 -> flags stays 4'b1001.
- Async reset mid-operation: count=2; drop rst_n between clock edges -> out_valid=0, flags=0 immediately; in_ready=1 after release.
- With the macro defined: 3 accepts with V=1 -> sticky_ov=1, ov_count=3. clr_sticky together with a V=1 accept -> sticky_ov=0, ov_count=0. CNT_W=2 with 5 overflow accepts -> ov_count saturates at 3.
